// File: rtl/datapath_core_param_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | datapath_core_param_if : control/source bundle for the datapath core       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface datapath_core_param_if #(
  parameter int DATA_W  = 16,
  parameter int NUM_SRC = 4,
  parameter int REG_AW  = 3
);
  logic [NUM_SRC-1:0]        Gate;
  logic [NUM_SRC*DATA_W-1:0] Src_Data;
  logic                      LD_REG;
  logic [REG_AW-1:0]         DR;
  logic [REG_AW-1:0]         SR1;
  logic [REG_AW-1:0]         SR2;
  logic                      LD_CC;
  logic                      LD_BEN;
  logic [2:0]                NZP_Mask;
  logic                      Clr_Err;
  logic [DATA_W-1:0]         BUS;
  logic [DATA_W-1:0]         SR1_OUT;
  logic [DATA_W-1:0]         SR2_OUT;
  logic [2:0]                CC;
  logic                      BEN;
  logic                      Bus_Err;
  logic [NUM_SRC-1:0]        Err_Src;

  modport master (
    output Gate, Src_Data, LD_REG, DR, SR1, SR2, LD_CC, LD_BEN, NZP_Mask, Clr_Err,
    input  BUS, SR1_OUT, SR2_OUT, CC, BEN, Bus_Err, Err_Src
  );

  modport slave (
    input  Gate, Src_Data, LD_REG, DR, SR1, SR2, LD_CC, LD_BEN, NZP_Mask, Clr_Err,
    output BUS, SR1_OUT, SR2_OUT, CC, BEN, Bus_Err, Err_Src
  );
endinterface
`default_nettype wire

// File: rtl/datapath_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | datapath_core_param : gated shared bus, register file, NZP and BEN latch   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module datapath_core_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_SRC  = 4,
  parameter int NUM_REGS = 8,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  wire logic             Clk,
  input  wire logic             Reset,
  datapath_core_param_if.slave  bus_if
);
  localparam logic [2:0] CC_RESET = 3'b010;

  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [2:0]         cc_q, cc_d;
  logic               ben_q, ben_d;
  logic               err_q, err_d;
  logic [NUM_SRC-1:0] err_src_q, err_src_d;

  logic [DATA_W-1:0]  bus_sel;
  logic [DATA_W-1:0]  sr1_rd, sr2_rd;
  logic               contention;

  // Descending scan so the lowest asserted gate wins under contention.
  always_comb begin
    bus_sel = hold_q;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus_if.Gate[i]) bus_sel = bus_if.Src_Data[i*DATA_W +: DATA_W];
    end
  end

  assign contention = |(bus_if.Gate & (bus_if.Gate - NUM_SRC'(1)));

  // DR matching an in-range index implies the write is legal, so no separate range check.
  always_comb begin
    sr1_rd = '0;
    sr2_rd = '0;
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus_if.SR1 == REG_AW'(i)) sr1_rd = regs_q[i];
      if (bus_if.SR2 == REG_AW'(i)) sr2_rd = regs_q[i];
      if (bus_if.LD_REG && bus_if.DR == REG_AW'(i)) begin
        regs_d[i] = bus_sel;
        if (bus_if.SR1 == REG_AW'(i)) sr1_rd = bus_sel;
        if (bus_if.SR2 == REG_AW'(i)) sr2_rd = bus_sel;
      end
    end
  end

  always_comb begin
    hold_d    = hold_q;
    cc_d      = cc_q;
    ben_d     = ben_q;
    err_d     = err_q;
    err_src_d = err_src_q;
    if (bus_if.Gate != '0) hold_d = bus_sel;
    if (bus_if.LD_CC) begin
      if (bus_sel[DATA_W-1])     cc_d = 3'b100;
      else if (bus_sel == '0)    cc_d = 3'b010;
      else                       cc_d = 3'b001;
    end
    if (bus_if.LD_BEN) ben_d = |(bus_if.NZP_Mask & cc_q);
    if (contention) begin
      err_d = 1'b1;
      if (!err_q || bus_if.Clr_Err) err_src_d = bus_if.Gate;
    end else if (bus_if.Clr_Err) begin
      err_d     = 1'b0;
      err_src_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      hold_q    <= '0;
      cc_q      <= CC_RESET;
      ben_q     <= 1'b0;
      err_q     <= 1'b0;
      err_src_q <= '0;
    end else begin
      regs_q    <= regs_d;
      hold_q    <= hold_d;
      cc_q      <= cc_d;
      ben_q     <= ben_d;
      err_q     <= err_d;
      err_src_q <= err_src_d;
    end
  end

  assign bus_if.BUS     = bus_sel;
  assign bus_if.SR1_OUT = sr1_rd;
  assign bus_if.SR2_OUT = sr2_rd;
  assign bus_if.CC      = cc_q;
  assign bus_if.BEN     = ben_q;
  assign bus_if.Bus_Err = err_q;
  assign bus_if.Err_Src = err_src_q;
endmodule
`default_nettype wire

// File: tb/tb_datapath_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_datapath_core_param : scoreboard bench with reference model             |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_datapath_core_param;
  localparam int NREGS = 6;

  typedef struct packed {
    logic [15:0] bus;
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [2:0]  cc;
    logic        ben;
    logic        err;
    logic [3:0]  esrc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [15:0] src [4];

  logic [15:0] m_reg [NREGS];
  logic [15:0] m_hold;
  logic [2:0]  m_cc;
  logic        m_ben;
  logic        m_err;
  logic [3:0]  m_esrc;
  bit          known = 1'b0;

  datapath_core_param_if #(.DATA_W(16), .NUM_SRC(4), .REG_AW(3)) dif ();

  datapath_core_param #(
    .DATA_W(16), .NUM_SRC(4), .NUM_REGS(NREGS)
  ) dut (
    .Clk(clk),
    .Reset(rst_n),
    .bus_if(dif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // Monitor: one DUT observation per cycle, compared against the oldest expectation.
  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("BUS",     dif.BUS,            mon_e.bus);
      chk("SR1_OUT", dif.SR1_OUT,        mon_e.sr1);
      chk("SR2_OUT", dif.SR2_OUT,        mon_e.sr2);
      chk("CC",      16'(dif.CC),        16'(mon_e.cc));
      chk("BEN",     16'(dif.BEN),       16'(mon_e.ben));
      chk("Bus_Err", 16'(dif.Bus_Err),   16'(mon_e.err));
      chk("Err_Src", 16'(dif.Err_Src),   16'(mon_e.esrc));
    end
  end

  function automatic logic [15:0] m_bus();
    if (dif.Gate == 4'd0) return m_hold;
    for (int i = 0; i < 4; i++) if (dif.Gate[i]) return src[i];
    return m_hold;
  endfunction

  function automatic logic [15:0] m_rd(input logic [2:0] idx, input logic [15:0] b);
    if (dif.LD_REG && dif.DR == idx && int'(dif.DR) < NREGS) return b;
    if (int'(idx) < NREGS) return m_reg[idx];
    return 16'd0;
  endfunction

  task automatic m_update(input logic [15:0] b);
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = 16'd0;
      m_hold = 16'd0; m_cc = 3'b010; m_ben = 1'b0; m_err = 1'b0; m_esrc = 4'd0;
      known  = 1'b1;
    end else begin
      if (dif.LD_REG && int'(dif.DR) < NREGS) m_reg[dif.DR] = b;
      if (dif.Gate != 4'd0) m_hold = b;
      if (dif.LD_BEN) m_ben = (dif.NZP_Mask & m_cc) != 3'd0;
      if (dif.LD_CC) m_cc = ($signed(b) < 0) ? 3'b100 : (b == 16'd0) ? 3'b010 : 3'b001;
      if ($countones(dif.Gate) >= 2) begin
        if (!m_err || dif.Clr_Err) m_esrc = dif.Gate;
        m_err = 1'b1;
      end else if (dif.Clr_Err) begin
        m_err = 1'b0; m_esrc = 4'd0;
      end
    end
  endtask

  task automatic cycle();
    exp_t        e;
    logic [15:0] b;
    dif.Src_Data = {src[3], src[2], src[1], src[0]};
    b = m_bus();
    if (known) begin
      e.bus = b; e.sr1 = m_rd(dif.SR1, b); e.sr2 = m_rd(dif.SR2, b);
      e.cc = m_cc; e.ben = m_ben; e.err = m_err; e.esrc = m_esrc;
      sb.push_back(e);
    end
    m_update(b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; dif.Gate = 4'd0; dif.LD_REG = 1'b0; dif.DR = 3'd0;
    dif.SR1 = 3'd0; dif.SR2 = 3'd0; dif.LD_CC = 1'b0; dif.LD_BEN = 1'b0;
    dif.NZP_Mask = 3'd0; dif.Clr_Err = 1'b0;
    foreach (src[i]) src[i] = 16'd0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    dif.Src_Data = '0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dif.SR1 = 3'(i); dif.SR2 = 3'(7 - i);
      cycle();
    end

    // Bypass then stored read
    idle(); dif.Gate = 4'b0001; src[0] = 16'h8003; dif.LD_REG = 1'b1; dif.DR = 3'd3; dif.SR1 = 3'd3;
    cycle();
    idle(); dif.SR1 = 3'd3;
    cycle();

    // Zero via source 2, idle hold, then negative
    idle(); dif.Gate = 4'b0100; dif.LD_CC = 1'b1;
    cycle();
    idle(); dif.LD_CC = 1'b1;
    cycle();
    idle(); dif.Gate = 4'b0010; src[1] = 16'hFFFF; dif.LD_CC = 1'b1;
    cycle();

    // BEN sees CC before the simultaneous CC load
    idle(); dif.Gate = 4'b0001; src[0] = 16'h0005; dif.LD_CC = 1'b1; dif.LD_BEN = 1'b1; dif.NZP_Mask = 3'b011;
    cycle();
    idle(); dif.LD_BEN = 1'b1; dif.NZP_Mask = 3'b011;
    cycle();
    idle();
    cycle();

    // Contention, sticky source capture, clear racing a new contention
    idle(); dif.Gate = 4'b0110; src[1] = 16'h1111; src[2] = 16'h2222;
    cycle();
    idle(); dif.Gate = 4'b1001; src[0] = 16'h0A0A; src[3] = 16'h3333;
    cycle();
    idle(); dif.Gate = 4'b1001; src[0] = 16'h0A0A; dif.Clr_Err = 1'b1;
    cycle();
    idle(); dif.Clr_Err = 1'b1;
    cycle();
    idle();
    cycle();

    // Out-of-range write/read, then reset during a write
    idle(); dif.Gate = 4'b1000; src[3] = 16'hABCD; dif.LD_REG = 1'b1; dif.DR = 3'd7; dif.SR1 = 3'd7; dif.SR2 = 3'd6;
    cycle();
    idle(); dif.SR1 = 3'd7; dif.SR2 = 3'd3;
    cycle();
    idle(); dif.Gate = 4'b0001; src[0] = 16'h1234; dif.LD_REG = 1'b1; dif.DR = 3'd2; dif.SR1 = 3'd2;
    cycle();
    idle(); dif.Gate = 4'b0001; src[0] = 16'h5678; dif.LD_REG = 1'b1; dif.DR = 3'd2; rst_n = 1'b0;
    cycle();
    idle(); dif.SR1 = 3'd2; dif.SR2 = 3'd3;
    cycle();

    for (int n = 0; n < 400; n++) begin
      int r;
      rst_n = ($urandom_range(0, 49) != 0);
      r = int'($urandom_range(0, 9));
      if (r < 2)      dif.Gate = 4'd0;
      else if (r < 8) dif.Gate = 4'(1 << $urandom_range(0, 3));
      else            dif.Gate = 4'($urandom_range(0, 15));
      foreach (src[i]) src[i] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      dif.LD_REG   = 1'($urandom_range(0, 1));
      dif.DR       = 3'($urandom_range(0, 7));
      dif.SR1      = 3'($urandom_range(0, 7));
      dif.SR2      = 3'($urandom_range(0, 7));
      dif.LD_CC    = 1'($urandom_range(0, 1));
      dif.LD_BEN   = 1'($urandom_range(0, 1));
      dif.NZP_Mask = 3'($urandom_range(0, 7));
      dif.Clr_Err  = ($urandom_range(0, 5) == 0);
      cycle();
    end

    idle();
    for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
